regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Parametrised register file with write-before-read bypass and a per-register pending-write scoreboard.
- Generalises the decode-stage register file in data width and register count.
- Adds interlock: it tracks in-flight writes issued from decode and raises a stall when a consumed source operand is still pending.
- Sits in the decode stage. Writeback drives the write port; the decode/issue logic drives the read selects and the issue port.

Parameters:
DATA_W, 16, register data width in bits
NREG, 8, number of architectural registers (power of two, >= 2)
SEL_W, 3, register select width; must equal log2(NREG)
PEND_W, 2, width of each pending counter; max outstanding writes per register = 2^PEND_W - 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
rd_sel_a  in  SEL_W  read port A select (Rs)
rd_sel_b  in  SEL_W  read port B select (Rt)
rd_use_a  in  1  instruction in decode consumes port A
rd_use_b  in  1  instruction in decode consumes port B
rd_data_a  out  DATA_W  port A data (bypassed)
rd_data_b  out  DATA_W  port B data (bypassed)
wr_en  in  1  writeback write enable
wr_sel  in  SEL_W  writeback destination
wr_data  in  DATA_W  writeback data
iss_valid  in  1  decode holds a valid instruction attempting to issue
iss_regwrite  in  1  issuing instruction writes a register
iss_sel  in  SEL_W  issuing instruction destination
flush  in  1  pipeline drained/squashed; clear all pending counters
stall  out  1  decode must hold; issue not accepted this cycle
pend_any  out  1  at least one register has a nonzero pending count (registered state)
err  out  1  sticky scoreboard over/underflow error

Behaviour:
- Reset (rst=0, async): all NREG registers = 0, all pending counters = 0, err = 0. While in reset: pend_any = 0, rd_data_x = 0 unless bypassed, stall = 0. Reset mid-operation discards all pending state immediately.
- Read ports (combinational):
  - rd_data_x = wr_data if wr_en & (wr_sel == rd_sel_x); otherwise reg[rd_sel_x].
  - Same-cycle write is visible; there is no read-side latency.
- Write port: on rising clk with wr_en=1, reg[wr_sel] <= wr_data. All registers are writable, including register 0.
- Per-register decrement term: dec[r] = wr_en & (wr_sel == r) & (pend[r] != 0).
- Effective busy: busy[r] = (pend[r] - dec[r]) != 0. A writeback landing this cycle clears the hazard in the same cycle.
- stall = (rd_use_a & busy[rd_sel_a]) | (rd_use_b & busy[rd_sel_b]). Purely combinational; iss_valid does not gate it.
- Issue fire: iss_fire = iss_valid & ~stall & ~flush.
- Per-register increment term: inc[r] = iss_fire & iss_regwrite & (iss_sel == r).
- Counter update on rising clk:
  - flush=1: all pend <= 0. Flush has priority over inc/dec; the register write still occurs.
  - Otherwise pend[r] <= pend[r] + inc[r] - dec[r].
  - inc and dec on the same register in the same cycle: no net change.
- Underflow: wr_en to r with pend[r] == 0 and flush=0 → err <= 1, counter stays 0, data write still performed.
- Overflow: inc[r]=1, dec[r]=0 and pend[r] == 2^PEND_W-1 → err <= 1, counter saturates.
- err is sticky until reset.
- pend_any = OR over r of (pend[r] != 0), taken from registered state.
- Self-dependency: the issuing instruction's own destination only affects later cycles, never its own stall.
- Arithmetic: counters are unsigned PEND_W bits; no wrap-around is permitted (saturate and flag instead).

Test Plan:
- Reset/bypass: after reset, read r3 → 0. Write r3=16'hBEEF while reading r3 → rd_data_a=16'hBEEF same cycle, reg holds BEEF next cycle.
- RAW stall: issue write to r2. Next cycle rd_sel_a=2, rd_use_a=1 → stall=1. Writeback r2=16'h1234 arrives → stall=0 that cycle and rd_data_a=16'h1234.
- Unused operand: pend[r5]=1, rd_sel_b=5, rd_use_b=0 → stall=0, iss_fire increments the target counter.
- Two in flight: issue r1 twice → pend=2. First writeback → stall stays 1. Second writeback → stall=0, pend_any=0.
- Simultaneous inc/dec on r4 with pend=1 → pend stays 1. Flush with pend[r1]=2, pend[r4]=1 → all 0 next cycle, pend_any=0, err=0.
- Errors: writeback r6 with pend=0 → err=1 sticky, data written. PEND_W=2: 4th issue to r0 → err=1, counter stays 3. Assert rst=0 mid-stream → err=0, pend_any=0 immediately.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with write-before-read bypass and per-register pending-write scoreboard.
// Latency: reads combinational (writeback bypassed same cycle); writes and counter updates take effect on the next rising edge.
// Backpressure: stall is raised while a consumed source has an outstanding write; a stalled issue is not accepted.
module regfile_scoreboard #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int SEL_W  = 3,
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEL_W-1:0]  rd_sel_a,
    input  logic [SEL_W-1:0]  rd_sel_b,
    input  logic              rd_use_a,
    input  logic              rd_use_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_valid,
    input  logic              iss_regwrite,
    input  logic [SEL_W-1:0]  iss_sel,
    input  logic              flush,
    output logic              stall,
    output logic              pend_any,
    output logic              err
);

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [PEND_W-1:0] pend_q [NREG];
    logic [PEND_W-1:0] pend_d [NREG];
    logic              err_q;
    logic              err_d;

    logic [NREG-1:0]   dec;
    logic [NREG-1:0]   inc;
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   nz;
    logic              iss_fire;

    // Hazard terms: a writeback landing now retires one pending write, clearing the hazard this cycle.
    always_comb begin
        dec  = '0;
        busy = '0;
        nz   = '0;
        for (int r = 0; r < NREG; r++) begin
            dec[r]  = wr_en && (wr_sel == SEL_W'(r)) && (pend_q[r] != '0);
            busy[r] = (pend_q[r] - PEND_W'(dec[r])) != '0;
            nz[r]   = pend_q[r] != '0;
        end
    end

    assign stall    = (rd_use_a & busy[rd_sel_a]) | (rd_use_b & busy[rd_sel_b]);
    assign iss_fire = iss_valid & ~stall & ~flush;

    // Increment term: only an accepted, register-writing issue claims its destination.
    always_comb begin
        inc = '0;
        for (int r = 0; r < NREG; r++) begin
            inc[r] = iss_fire && iss_regwrite && (iss_sel == SEL_W'(r));
        end
    end

    assign rd_data_a = (wr_en && (wr_sel == rd_sel_a)) ? wr_data : regs_q[rd_sel_a];
    assign rd_data_b = (wr_en && (wr_sel == rd_sel_b)) ? wr_data : regs_q[rd_sel_b];
    assign pend_any  = |nz;
    assign err       = err_q;

    // Next state: data write always lands; flush zeroes counters; otherwise saturating inc/dec with error flagging.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        err_d  = err_q;
        if (wr_en) begin
            regs_d[wr_sel] = wr_data;
        end
        if (flush) begin
            for (int r = 0; r < NREG; r++) begin
                pend_d[r] = '0;
            end
        end else begin
            // Writeback with nothing outstanding is an underflow; the counter stays at zero.
            if (wr_en && (pend_q[wr_sel] == '0)) begin
                err_d = 1'b1;
            end
            for (int r = 0; r < NREG; r++) begin
                if (inc[r] && !dec[r]) begin
                    if (pend_q[r] == PEND_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        pend_d[r] = pend_q[r] + PEND_ONE;
                    end
                end else if (dec[r] && !inc[r]) begin
                    pend_d[r] = pend_q[r] - PEND_ONE;
                end
            end
        end
    end

    // State registers; reset discards all pending state immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

endmodule
